// File: rtl/apb_master_bridge_if.sv
// Command/response and APB3 bus signals of the APB master bridge.
// master = bridge side, slave = command source plus APB slave side.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 master: one command in, one SETUP/ACCESS transfer out,
// one response pulse back, with an ACCESS-phase timeout against hung slaves.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_master_bridge_if.master bus,
    output logic [1:0]          state_dbg
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    // Handshake: a command transfers on a PCLK edge where cmd_valid && cmd_ready;
    // cmd_* are don't-care otherwise. rsp_valid is a one-cycle pulse with no ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A ready slave wins over a timeout firing on the same edge.
                if (bus.PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
                    state_d     = IDLE;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Bus controls are registered copies of what the next state implies.
        cmd_ready_d = (state_d == IDLE);
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a small memory-backed APB slave with
// per-transfer wait-state and error control, checked against hand-computed values.
module tb_apb_master_bridge;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    apb_master_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH    (4),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK     (clk),
        .PRESETn  (rst_n),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave memory and read-data override
    logic [31:0] mem [16];
    logic        force_rd;
    logic [31:0] force_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) begin
            mem[bus.PADDR] <= bus.PWDATA;
        end
    end

    assign bus.PRDATA = force_rd ? force_val : mem[bus.PADDR];

    // scoreboard state
    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // results of the last run_xfer
    int          r_lat;
    int          r_psel;
    int          r_bad;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_ready_at_rsp;
    logic        r_psel_at_rsp;

    // waits: ACCESS cycles with PREADY=0 before PREADY=1; -1 = never ready.
    // err_mode: 0 none, 1 PSLVERR always in ACCESS, 2 PSLVERR only on wait cycles.
    task automatic run_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                            input int waits, input int err_mode);
        int          acc;
        logic [3:0]  s_addr;
        logic        s_write;
        logic [31:0] s_wdata;
        acc    = 0;
        r_lat  = -1;
        r_psel = 0;
        r_bad  = 0;
        r_rdata = 32'hX;
        r_err   = 1'bX;
        r_ready_at_rsp = 1'b0;
        r_psel_at_rsp  = 1'b1;
        s_addr  = '0;
        s_write = 1'b0;
        s_wdata = '0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        if (!bus.cmd_ready) r_bad++;
        tick();
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            if (bus.rsp_valid) begin
                r_lat          = c;
                r_rdata        = bus.rsp_rdata;
                r_err          = bus.rsp_err;
                r_ready_at_rsp = bus.cmd_ready;
                r_psel_at_rsp  = bus.PSEL;
                break;
            end
            if (bus.PSEL) begin
                r_psel++;
                if (bus.cmd_ready) r_bad++;
                if (r_psel == 1) begin
                    s_addr  = bus.PADDR;
                    s_write = bus.PWRITE;
                    s_wdata = bus.PWDATA;
                    if (bus.PENABLE) r_bad++;
                    if (s_addr != a || s_write != w || (w && s_wdata != d)) r_bad++;
                end else if (bus.PADDR != s_addr || bus.PWRITE != s_write || bus.PWDATA != s_wdata) begin
                    r_bad++;
                end
            end
            if (bus.PSEL && bus.PENABLE) begin
                acc++;
                bus.PREADY  = (waits >= 0) && (acc > waits);
                bus.PSLVERR = (err_mode == 1) || ((err_mode == 2) && !bus.PREADY);
            end else begin
                bus.PREADY  = (waits == 0);
                bus.PSLVERR = 1'b0;
            end
            tick();
        end
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
    endtask

    int   idx;
    int   last_acc;
    int   gap_bad;
    int   en_bad;
    int   n_rsp;
    logic acc_now;
    logic saw_rsp;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        force_rd  = 1'b0;
        force_val = 32'h0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;
        rst_n = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        check_eq("rst_rsp", {29'h0, bus.rsp_valid, bus.rsp_err, 1'b0}, 32'h0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_psel_penable", {30'h0, bus.PSEL, bus.PENABLE}, 32'h0);
        check_eq("rst_paddr_pwrite", {27'h0, bus.PADDR, bus.PWRITE}, 32'h0);
        check_eq("rst_pwdata", bus.PWDATA, 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("ready_before_edge", 32'(bus.cmd_ready), 32'h0);
        tick();
        check_eq("ready_after_edge", 32'(bus.cmd_ready), 32'h1);
        check_eq("state_idle", 32'(state_dbg), 32'(ST_IDLE));

        // zero-wait write then read
        run_xfer(1'b1, 4'h0, 32'hDEADBEEF, 0, 0);
        check_eq("wr0_lat", r_lat, 32'd3);
        check_eq("wr0_psel_cycles", r_psel, 32'd2);
        check_eq("wr0_err", 32'(r_err), 32'h0);
        check_eq("wr0_rdata", r_rdata, 32'h0);
        check_eq("wr0_protocol", r_bad, 32'd0);
        check_eq("wr0_ready_psel_at_rsp", {30'h0, r_ready_at_rsp, r_psel_at_rsp}, 32'h2);
        check_eq("wr0_mem", mem[0], 32'hDEADBEEF);

        run_xfer(1'b0, 4'h0, 32'h0, 0, 0);
        check_eq("rd0_lat", r_lat, 32'd3);
        check_eq("rd0_psel_cycles", r_psel, 32'd2);
        check_eq("rd0_rdata", r_rdata, 32'hDEADBEEF);
        check_eq("rd0_err", 32'(r_err), 32'h0);

        // three wait states
        run_xfer(1'b0, 4'h0, 32'h0, 3, 0);
        check_eq("rdw3_lat", r_lat, 32'd6);
        check_eq("rdw3_psel_cycles", r_psel, 32'd5);
        check_eq("rdw3_stable", r_bad, 32'd0);
        check_eq("rdw3_rdata", r_rdata, 32'hDEADBEEF);
        check_eq("rdw3_err", 32'(r_err), 32'h0);

        // PREADY stuck low: abort after 16 ACCESS cycles
        run_xfer(1'b0, 4'h0, 32'h0, -1, 0);
        check_eq("to_lat", r_lat, 32'd18);
        check_eq("to_psel_cycles", r_psel, 32'd17);
        check_eq("to_err", 32'(r_err), 32'h1);
        check_eq("to_rdata", r_rdata, 32'h0);
        check_eq("to_ready_psel_at_rsp", {30'h0, r_ready_at_rsp, r_psel_at_rsp}, 32'h2);
        check_eq("to_penable", 32'(bus.PENABLE), 32'h0);

        // PREADY on exactly the 16th ACCESS cycle completes normally
        run_xfer(1'b0, 4'h0, 32'h0, 15, 0);
        check_eq("edge16_lat", r_lat, 32'd18);
        check_eq("edge16_err", 32'(r_err), 32'h0);
        check_eq("edge16_rdata", r_rdata, 32'hDEADBEEF);

        // slave error on the completing edge zeroes read data
        force_rd  = 1'b1;
        force_val = 32'h12345678;
        run_xfer(1'b0, 4'h1, 32'h0, 0, 1);
        check_eq("slverr_err", 32'(r_err), 32'h1);
        check_eq("slverr_rdata", r_rdata, 32'h0);
        check_eq("slverr_lat", r_lat, 32'd3);

        // PSLVERR only during wait cycles is ignored
        run_xfer(1'b0, 4'h1, 32'h0, 2, 2);
        check_eq("waiterr_err", 32'(r_err), 32'h0);
        check_eq("waiterr_rdata", r_rdata, 32'h12345678);
        check_eq("waiterr_lat", r_lat, 32'd5);
        force_rd = 1'b0;

        // back-to-back writes with cmd_valid held high
        exp_q.delete();
        idx = 0; last_acc = -1; gap_bad = 0; en_bad = 0; n_rsp = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'h0;
        bus.cmd_wdata = 32'hB0000000;
        for (int c = 0; c < 30; c++) begin
            acc_now = bus.cmd_valid && bus.cmd_ready;
            if (acc_now) begin
                exp_q.push_back(32'h0);
                if (last_acc >= 0 && (c - last_acc) != 3) gap_bad++;
                last_acc = c;
            end
            tick();
            if (acc_now) begin
                idx++;
                if (idx == 3) bus.cmd_valid = 1'b0;
                else begin
                    bus.cmd_addr  = 4'(idx);
                    bus.cmd_wdata = 32'hB0000000 + 32'(idx);
                end
            end
            if (state_dbg == ST_SETUP && bus.PENABLE) en_bad++;
            if (bus.rsp_valid) begin
                n_rsp++;
                if (exp_q.size() == 0) check_eq("b2b_unexpected_rsp", 32'(n_rsp), 32'h0);
                else check_eq("b2b_rdata", bus.rsp_rdata, exp_q.pop_front());
            end
        end
        check_eq("b2b_rsp_count", n_rsp, 32'd3);
        check_eq("b2b_last_accept", last_acc, 32'd6);
        check_eq("b2b_gap", gap_bad, 32'd0);
        check_eq("b2b_penable_in_setup", en_bad, 32'd0);
        check_eq("b2b_queue_empty", exp_q.size(), 32'd0);
        run_xfer(1'b0, 4'h1, 32'h0, 0, 0);
        check_eq("b2b_rd1", r_rdata, 32'hB0000001);
        run_xfer(1'b0, 4'h2, 32'h0, 1, 0);
        check_eq("b2b_rd2", r_rdata, 32'hB0000002);
        check_eq("b2b_rd2_lat", r_lat, 32'd4);

        // reset asserted mid-ACCESS
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'h0;
        tick();
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        tick();
        tick();
        check_eq("mid_state_access", 32'(state_dbg), 32'(ST_ACCESS));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_async_drop", {29'h0, bus.PSEL, bus.PENABLE, bus.cmd_ready}, 32'h0);
        saw_rsp = 1'b0;
        bus.PREADY = 1'b1;
        repeat (3) begin
            tick();
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        rst_n = 1'b1;
        #1;
        if (bus.rsp_valid) saw_rsp = 1'b1;
        check_eq("mid_no_rsp", 32'(saw_rsp), 32'h0);
        check_eq("mid_ready_before_edge", 32'(bus.cmd_ready), 32'h0);
        tick();
        check_eq("mid_ready_after_edge", 32'(bus.cmd_ready), 32'h1);
        run_xfer(1'b1, 4'h3, 32'hCAFEF00D, 0, 0);
        check_eq("post_rst_wr_lat", r_lat, 32'd3);
        check_eq("post_rst_wr_err", 32'(r_err), 32'h0);
        run_xfer(1'b0, 4'h3, 32'h0, 0, 0);
        check_eq("post_rst_rd", r_rdata, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
